bcd_down_divider: RTL and testbench

Loadable two-digit BCD down-counter and programmable divider, the count-down counterpart of the block's up-counting mod-80 BCD divider. It decrements on each enabled cycle and emits a one-cycle borrow pulse `bout` on underflow past 00. It either reloads from a programmable value (periodic divider) or stops in a done state (one-shot timer). It sits beside the up-counter in the timing chain and feeds `bout` to downstream stages as their count enable.

---
 rtl/bcd_div_pkg.sv | 22 ++
 rtl/bcd2_dec.sv | 28 ++
 rtl/bcd_down_divider.sv | 121 ++++++++++++
 tb/tb_bcd_down_divider.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_div_pkg.sv
// Shared types and constants for the two-digit BCD down-counter/divider.
// Also holds the BCD load-value check used by the top block.
package bcd_div_pkg;

  localparam int UNITS_W = 4;
  localparam int TENS_W  = 3;
  localparam int BCD_W   = TENS_W + UNITS_W;

  localparam logic [BCD_W-1:0] DEFAULT_LOAD_C = 7'h79;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Tens is 3 bits and always in range, so only the units digit needs checking.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    return v[UNITS_W-1:0] <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd2_dec.sv
// Combinational two-digit BCD decrement with a zero flag.
// At 00 the output is 00; the caller decides what underflow means.
module bcd2_dec
  import bcd_div_pkg::*;
(
  input  logic [BCD_W-1:0] val_i,
  output logic [BCD_W-1:0] dec_o,
  output logic             zero_o
);

  logic [TENS_W-1:0]  tens;
  logic [UNITS_W-1:0] units;

  always_comb begin
    tens   = val_i[BCD_W-1:UNITS_W];
    units  = val_i[UNITS_W-1:0];
    zero_o = (val_i == '0);
    dec_o  = '0;
    if (!zero_o) begin
      if (units != '0) begin
        dec_o = {tens, units - 4'd1};
      end else begin
        dec_o = {tens - 3'd1, 4'd9};
      end
    end
  end

endmodule

// File: rtl/bcd_down_divider.sv
// Loadable two-digit BCD down-counter: periodic divider (auto_reload=1) or
// one-shot timer (auto_reload=0), with a registered borrow pulse on underflow.
module bcd_down_divider
  import bcd_div_pkg::*;
#(
  parameter logic [6:0] DEFAULT_LOAD = DEFAULT_LOAD_C
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       Bin,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       auto_reload,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] count,
  output logic       bout,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic [6:0] reload_q, reload_d;
  logic       bout_q, bout_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [6:0] count_dec;
  logic       count_zero;
  logic       load_ok;

  bcd2_dec u_dec (
    .val_i  (count_q),
    .dec_o  (count_dec),
    .zero_o (count_zero)
  );

  assign load_ok = bcd_valid(load_val);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    bout_d   = 1'b0;
    err_d    = 1'b0;

    if (stop) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
      end
    end else if (start && state_q != ST_RUN) begin
      state_d = ST_RUN;
      if (state_q == ST_DONE) begin
        count_d = reload_q;
      end
      // A load in the same cycle as the start still lands; it overrides the reload.
      if (load) begin
        if (load_ok) begin
          reload_d = load_val;
          count_d  = load_val;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (state_q == ST_RUN) begin
      if (Bin) begin
        if (count_zero) begin
          bout_d = 1'b1;
          if (auto_reload) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_dec;
        end
      end
    end else if (load) begin
      if (load_ok) begin
        reload_d = load_val;
        count_d  = load_val;
      end else begin
        err_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      count_q  <= DEFAULT_LOAD;
      reload_q <= DEFAULT_LOAD;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign bout  = bout_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_down_divider.sv
// Self-checking bench for bcd_down_divider: a directed vector table plus
// hand-written sequences for divider periods, auto-reload at 00 and async reset.
module tb_bcd_down_divider;

  logic       clk;
  logic       Rst;
  logic       Bin;
  logic       load;
  logic [6:0] load_val;
  logic       auto_reload;
  logic       start;
  logic       stop;
  logic [6:0] count;
  logic       bout;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;

  bcd_down_divider dut (
    .clk         (clk),
    .Rst         (Rst),
    .Bin         (Bin),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .start       (start),
    .stop        (stop),
    .count       (count),
    .bout        (bout),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [6:0] lv;
    logic       st;
    logic       sp;
    logic       bin;
    logic       ar;
    logic [6:0] ec;
    logic       ebusy;
    logic       edone;
    logic       ebout;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic add(input logic ld, input logic [6:0] lv, input logic st, input logic sp,
                     input logic bin, input logic ar, input logic [6:0] ec,
                     input logic ebusy, input logic edone, input logic ebout, input logic eerr);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.bin = bin; v.ar = ar;
    v.ec = ec; v.ebusy = ebusy; v.edone = edone; v.ebout = ebout; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic ld, input logic [6:0] lv, input logic st, input logic sp,
                     input logic bin, input logic ar);
    @(negedge clk);
    load = ld; load_val = lv; start = st; stop = sp; Bin = bin; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Rst = 1'b1;
    load = 1'b0; start = 1'b0; stop = 1'b0; Bin = 1'b0; auto_reload = 1'b0; load_val = 7'h00;
    @(negedge clk);
    Rst = 1'b0;
  endtask

  function automatic logic [6:0] to_bcd(input int v);
    logic [2:0] t;
    logic [3:0] u;
    t = 3'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  initial begin
    int model;
    int last_bout;
    int nbout;
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    Bin = 1'b0; load = 1'b0; load_val = 7'h00; auto_reload = 1'b0; start = 1'b0; stop = 1'b0;

    //   ld lv     st sp bin ar  count  busy done bout err
    add(1, 7'h2A, 0, 0, 0, 0, 7'h79, 0, 0, 0, 1);
    add(0, 7'h00, 0, 0, 0, 0, 7'h79, 0, 0, 0, 0);
    add(1, 7'h03, 0, 0, 0, 0, 7'h03, 0, 0, 0, 0);
    add(0, 7'h00, 1, 0, 1, 0, 7'h03, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h02, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h01, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h00, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h00, 0, 1, 1, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h00, 0, 1, 0, 0);
    add(0, 7'h00, 1, 0, 1, 0, 7'h03, 1, 0, 0, 0);
    add(1, 7'h45, 0, 0, 0, 0, 7'h03, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h02, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 0, 0, 7'h02, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h01, 1, 0, 0, 0);
    add(0, 7'h00, 1, 1, 1, 0, 7'h01, 0, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h01, 0, 0, 0, 0);
    add(0, 7'h00, 1, 0, 0, 0, 7'h01, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h00, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 0, 7'h00, 0, 1, 1, 0);
    add(0, 7'h00, 0, 1, 0, 0, 7'h00, 0, 0, 0, 0);
    add(1, 7'h10, 0, 0, 0, 1, 7'h10, 0, 0, 0, 0);
    add(0, 7'h00, 1, 0, 1, 1, 7'h10, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 1, 7'h09, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 1, 7'h08, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(count), 'h79);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_bout", int'(bout), 0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);
    Rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].bin, vecs[i].ar);
      $display("vec %0d: ld=%0b lv=%h st=%0b sp=%0b bin=%0b ar=%0b -> count=%h busy=%0b done=%0b bout=%0b err=%0b",
               i, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].bin, vecs[i].ar,
               count, busy, done, bout, err);
      chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].ec));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].ebusy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].edone));
      chk($sformatf("vec%0d_bout", i), int'(bout), int'(vecs[i].ebout));
      chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].eerr));
    end

    // Divide by 13: reload 12, Bin held high.
    do_reset();
    cyc(1, 7'h12, 0, 0, 0, 1);
    cyc(0, 7'h00, 1, 0, 1, 1);
    chk("div13_start_count", int'(count), 'h12);
    model = 12; last_bout = -1; nbout = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(0, 7'h00, 0, 0, 1, 1);
      if (model == 0) model = 12; else model--;
      chk("div13_count", int'(count), int'(to_bcd(model)));
      chk("div13_bout", int'(bout), (k % 13 == 12) ? 1 : 0);
      if (bout) begin
        if (last_bout >= 0) chk("div13_period", k - last_bout, 13);
        last_bout = k;
        nbout++;
      end
    end
    chk("div13_nbout", nbout, 2);
    $display("div13 sequence: %0d borrows", nbout);

    // Default reload 79: divide by 80 over 200 cycles.
    do_reset();
    cyc(0, 7'h00, 1, 0, 1, 1);
    chk("div80_start_count", int'(count), 'h79);
    model = 79; last_bout = -1; nbout = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(0, 7'h00, 0, 0, 1, 1);
      if (model == 0) model = 79; else model--;
      chk("div80_count", int'(count), int'(to_bcd(model)));
      chk("div80_bout", int'(bout), (k % 80 == 79) ? 1 : 0);
      if (bout) begin
        if (last_bout >= 0) chk("div80_period", k - last_bout, 80);
        last_bout = k;
        nbout++;
      end
    end
    chk("div80_nbout", nbout, 2);
    $display("div80 sequence: %0d borrows", nbout);

    // Reload 00 with auto-reload: borrow every enabled cycle.
    do_reset();
    cyc(1, 7'h00, 0, 0, 0, 1);
    cyc(0, 7'h00, 1, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 7'h00, 0, 0, 1, 1);
      chk("n00_count", int'(count), 0);
      chk("n00_bout", int'(bout), 1);
      chk("n00_busy", int'(busy), 1);
    end
    $display("n00 sequence done");

    // Asynchronous reset between edges, while a borrow pulse is high.
    @(negedge clk);
    #2;
    Rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 'h79);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_bout", int'(bout), 0);
    @(negedge clk);
    Rst = 1'b0;
    Bin = 1'b0; start = 1'b0;
    cyc(0, 7'h00, 0, 0, 1, 1);
    chk("arst_idle_hold", int'(count), 'h79);
    $display("async reset sequence done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
